// File: rtl/nes_vga_scaler.sv
// nes_vga_scaler: line-doubling NES (256x240) to VGA (640x480) scaler built on two ping-pong line banks.
// Optional macro NES_VGA_SCANLINE_EN halves every colour channel on odd VGA rows.
module nes_vga_scaler (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    input  logic       h_sync_in,
    input  logic       v_sync_in,
    input  logic       blank_in,
    output logic       line_req,
    output logic [7:0] line_num,
    input  logic       ppu_valid,
    input  logic [5:0] ppu_pix,
    output logic       ppu_ready,
    output logic [3:0] rgb_r,
    output logic [3:0] rgb_g,
    output logic [3:0] rgb_b,
    output logic       h_sync,
    output logic       v_sync,
    output logic       underrun
);

    logic [5:0]  bank_mem [0:511];
    logic        bank_sel;
    logic [8:0]  fill_cnt;
    logic        outstanding;
    logic        swap_row;
    logic        swap;
    logic        ready_q;
    logic        wr_en;
    logic [8:0]  target;

    logic [7:0]  rd_addr;
    logic        rd_act;
    logic [5:0]  s1_pix;
    logic        s1_act;
    logic        s1_hs;
    logic        s1_vs;
    logic        s1_blank;
`ifdef NES_VGA_SCANLINE_EN
    logic        s1_odd;
`endif
    logic [11:0] pal_c;

    function automatic logic [11:0] nes_palette(input logic [5:0] idx);
        logic [11:0] c;
        case (idx)
            6'h00: c = 12'h777;
            6'h01: c = 12'h00F;
            6'h02: c = 12'h00B;
            6'h03: c = 12'h42B;
            6'h04: c = 12'h908;
            6'h05: c = 12'hA02;
            6'h06: c = 12'hA10;
            6'h07: c = 12'h810;
            6'h08: c = 12'h530;
            6'h09: c = 12'h070;
            6'h0A: c = 12'h060;
            6'h0B: c = 12'h050;
            6'h0C: c = 12'h045;
            6'h10: c = 12'hBBB;
            6'h11: c = 12'h07F;
            6'h12: c = 12'h05F;
            6'h13: c = 12'h64F;
            6'h14: c = 12'hD0C;
            6'h15: c = 12'hE05;
            6'h16: c = 12'hF30;
            6'h17: c = 12'hE51;
            6'h18: c = 12'hA70;
            6'h19: c = 12'h0B0;
            6'h1A: c = 12'h0A0;
            6'h1B: c = 12'h0A4;
            6'h1C: c = 12'h088;
            6'h20: c = 12'hFFF;
            6'h21: c = 12'h3BF;
            6'h22: c = 12'h68F;
            6'h23: c = 12'h97F;
            6'h24: c = 12'hF7F;
            6'h25: c = 12'hF59;
            6'h26: c = 12'hF75;
            6'h27: c = 12'hFA4;
            6'h28: c = 12'hFB0;
            6'h29: c = 12'hBF1;
            6'h2A: c = 12'h5D5;
            6'h2B: c = 12'h5F9;
            6'h2C: c = 12'h0ED;
            6'h2D: c = 12'h777;
            6'h30: c = 12'hFFF;
            6'h31: c = 12'hAEF;
            6'h32: c = 12'hBBF;
            6'h33: c = 12'hDBF;
            6'h34: c = 12'hFBF;
            6'h35: c = 12'hFAC;
            6'h36: c = 12'hFDB;
            6'h37: c = 12'hFEA;
            6'h38: c = 12'hFD7;
            6'h39: c = 12'hDF7;
            6'h3A: c = 12'hBFB;
            6'h3B: c = 12'hBFD;
            6'h3C: c = 12'h0FF;
            6'h3D: c = 12'hFDF;
            // x0D..x0F and xE/xF columns (including 0x0F) are black
            default: c = 12'h000;
        endcase
        return c;
    endfunction

    // Swap rows: 522 and 524 prime NES lines 0 and 1, then every odd row up to 477.
    always_comb begin
        swap_row  = (v_cnt == 10'd522) || (v_cnt == 10'd524) ||
                    (v_cnt[0] && (v_cnt <= 10'd477));
        swap      = en && (h_cnt == 10'd799) && swap_row;
        if (v_cnt == 10'd522)
            target = 9'd0;
        else if (v_cnt == 10'd524)
            target = 9'd1;
        else
            target = v_cnt[9:1] + 9'd2;
        ready_q   = outstanding && !fill_cnt[8];
        ppu_ready = ready_q && !swap && !rst;
        wr_en     = ppu_valid && ppu_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_sel    <= 1'b0;
            fill_cnt    <= '0;
            outstanding <= 1'b0;
            underrun    <= 1'b0;
            line_req    <= 1'b0;
            line_num    <= '0;
        end else begin
            line_req <= 1'b0;
            if (swap) begin
                bank_sel <= ~bank_sel;
                fill_cnt <= '0;
                if (ready_q)
                    underrun <= 1'b1;
                if (target <= 9'd239) begin
                    line_req    <= 1'b1;
                    line_num    <= target[7:0];
                    outstanding <= 1'b1;
                end else begin
                    outstanding <= 1'b0;
                end
            end else if (wr_en) begin
                fill_cnt <= fill_cnt + 9'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            bank_mem[{~bank_sel, fill_cnt[7:0]}] <= ppu_pix;
    end

    // (h_cnt-64)>>1 over 64..575, folded to 8 bits as h_cnt[8:1]-32 modulo 256.
    assign rd_act  = (h_cnt >= 10'd64) && (h_cnt <= 10'd575);
    assign rd_addr = h_cnt[8:1] - 8'd32;

    always_ff @(posedge clk) begin
        if (en)
            s1_pix <= bank_mem[{bank_sel, rd_addr}];
    end

    assign pal_c = nes_palette(s1_pix);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_act   <= 1'b0;
            s1_hs    <= 1'b1;
            s1_vs    <= 1'b0;
            s1_blank <= 1'b1;
`ifdef NES_VGA_SCANLINE_EN
            s1_odd   <= 1'b0;
`endif
            h_sync   <= 1'b1;
            v_sync   <= 1'b0;
            rgb_r    <= '0;
            rgb_g    <= '0;
            rgb_b    <= '0;
        end else if (en) begin
            s1_act   <= rd_act;
            s1_hs    <= h_sync_in;
            s1_vs    <= v_sync_in;
            s1_blank <= blank_in;
`ifdef NES_VGA_SCANLINE_EN
            s1_odd   <= v_cnt[0];
`endif
            h_sync   <= s1_hs;
            v_sync   <= s1_vs;
            if (s1_blank || !s1_act) begin
                rgb_r <= '0;
                rgb_g <= '0;
                rgb_b <= '0;
`ifdef NES_VGA_SCANLINE_EN
            end else if (s1_odd) begin
                rgb_r <= pal_c[11:8] >> 1;
                rgb_g <= pal_c[7:4] >> 1;
                rgb_b <= pal_c[3:0] >> 1;
`endif
            end else begin
                rgb_r <= pal_c[11:8];
                rgb_g <= pal_c[7:4];
                rgb_b <= pal_c[3:0];
            end
        end
    end

endmodule

// File: tb/tb_nes_vga_scaler.sv
// Directed bench for nes_vga_scaler: the bench acts as timing generator and PPU, with table-driven pixel checks.
module tb_nes_vga_scaler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [9:0] h_cnt = '0;
    logic [9:0] v_cnt = '0;
    logic       h_sync_in = 1'b1;
    logic       v_sync_in = 1'b0;
    logic       blank_in = 1'b1;
    logic       line_req;
    logic [7:0] line_num;
    logic       ppu_valid = 1'b0;
    logic [5:0] ppu_pix = '0;
    logic       ppu_ready;
    logic [3:0] rgb_r, rgb_g, rgb_b;
    logic       h_sync, v_sync;
    logic       underrun;

    nes_vga_scaler dut (
        .clk(clk), .rst(rst), .en(en), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .blank_in(blank_in),
        .line_req(line_req), .line_num(line_num),
        .ppu_valid(ppu_valid), .ppu_pix(ppu_pix), .ppu_ready(ppu_ready),
        .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
        .h_sync(h_sync), .v_sync(v_sync), .underrun(underrun)
    );

    always #20 clk = ~clk;

    typedef struct {
        int          tab;
        int          h;
        logic [11:0] rgb;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_errors = 0;
    int h_pos = 0, v_pos = 0;
    bit en_v = 1'b1;
    int wr_cnt = 0, fill_limit = 0;
    bit fill_on = 1'b0, ramp_mode = 1'b0, acc = 1'b0;
    int hh1 = -1, hv1 = -1, hh2 = -1, hv2 = -1;
    int chk_row = -1, tab_sel = 0;
    bit blank_mon = 1'b0;
    int blank_rgb_bad = 0, blank_ready_bad = 0;

    function automatic logic [11:0] rgb_now();
        return {rgb_r, rgb_g, rgb_b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        en        = en_v;
        h_cnt     = 10'(h_pos);
        v_cnt     = 10'(v_pos);
        blank_in  = (h_pos >= 640) || (v_pos >= 480);
        h_sync_in = !((h_pos >= 656) && (h_pos < 752));
        v_sync_in = (v_pos == 490) || (v_pos == 491);
        ppu_valid = fill_on && (wr_cnt < fill_limit);
        ppu_pix   = ramp_mode ? 6'(wr_cnt % 64) : 6'h30;
        #1;
        acc = ppu_valid && ppu_ready;
    endtask

    task automatic scan_check();
        if (chk_row >= 0 && hv2 == chk_row) begin
            foreach (vecs[i])
                if (vecs[i].tab == tab_sel && vecs[i].h == hh2)
                    check($sformatf("rgb_row%0d_h%0d", hv2, hh2), 32'(rgb_now()), 32'(vecs[i].rgb));
            if (hh2 == 655 || hh2 == 656 || hh2 == 751 || hh2 == 752)
                check($sformatf("h_sync_delay_h%0d", hh2), 32'(h_sync),
                      32'(!((hh2 >= 656) && (hh2 < 752))));
        end
        if (blank_mon) begin
            if (rgb_now() != 12'h000) blank_rgb_bad++;
            if (ppu_ready) blank_ready_bad++;
            if (hv2 >= 489 && hv2 <= 492 && (hh2 <= 1 || hh2 >= 798))
                check($sformatf("v_sync_delay_v%0d_h%0d", hv2, hh2), 32'(v_sync),
                      32'((hv2 == 490) || (hv2 == 491)));
        end
    endtask

    // Edge happens with the inputs currently driven; the position model advances only if en was high.
    task automatic tick();
        @(posedge clk);
        #1;
        if (acc) wr_cnt++;
        if (en) begin
            hh2 = hh1; hv2 = hv1; hh1 = h_pos; hv1 = v_pos;
            h_pos++;
            if (h_pos == 800) begin
                h_pos = 0;
                v_pos++;
                if (v_pos == 525) v_pos = 0;
            end
        end
        drive();
        scan_check();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic jump(input int v, input int h);
        v_pos = v;
        h_pos = h;
        drive();
    endtask

    task automatic swap_at(input int v);
        jump(v, 795);
        repeat (5) tick();
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_rgb"}, 32'(rgb_now()), 32'h000);
        check({tag, "_h_sync"}, 32'(h_sync), 32'h1);
        check({tag, "_v_sync"}, 32'(v_sync), 32'h0);
        check({tag, "_line_req"}, 32'(line_req), 32'h0);
        check({tag, "_line_num"}, 32'(line_num), 32'h0);
        check({tag, "_ppu_ready"}, 32'(ppu_ready), 32'h0);
        check({tag, "_underrun"}, 32'(underrun), 32'h0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // tab 1: white line on even row, tab 2: white line on odd row, tab 3: ramp line
        vecs.push_back('{1, 0, 12'h000});
        vecs.push_back('{1, 63, 12'h000});
        vecs.push_back('{1, 64, 12'hFFF});
        vecs.push_back('{1, 320, 12'hFFF});
        vecs.push_back('{1, 575, 12'hFFF});
        vecs.push_back('{1, 576, 12'h000});
        vecs.push_back('{1, 639, 12'h000});
`ifdef NES_VGA_SCANLINE_EN
        vecs.push_back('{2, 64, 12'h777});
        vecs.push_back('{2, 575, 12'h777});
`else
        vecs.push_back('{2, 64, 12'hFFF});
        vecs.push_back('{2, 575, 12'hFFF});
`endif
        vecs.push_back('{2, 63, 12'h000});
        vecs.push_back('{2, 576, 12'h000});
        vecs.push_back('{3, 0, 12'h000});
        vecs.push_back('{3, 63, 12'h000});
        vecs.push_back('{3, 64, 12'h777});
        vecs.push_back('{3, 65, 12'h777});
        vecs.push_back('{3, 66, 12'h00F});
        vecs.push_back('{3, 67, 12'h00F});
        vecs.push_back('{3, 94, 12'h000});
        vecs.push_back('{3, 108, 12'hF30});
        vecs.push_back('{3, 148, 12'h5D5});
        vecs.push_back('{3, 160, 12'hFFF});
        vecs.push_back('{3, 190, 12'h000});
        vecs.push_back('{3, 192, 12'h777});
        vecs.push_back('{3, 304, 12'hFD7});
        vecs.push_back('{3, 570, 12'hFDF});
        vecs.push_back('{3, 576, 12'h000});
        vecs.push_back('{3, 639, 12'h000});

        rst = 1'b1;
        jump(0, 0);
        repeat (3) tick();
        reset_checks("por");
        rst = 1'b0;
        drive();

        // First request for NES line 0, then a constant white fill.
        fill_on = 1'b1; ramp_mode = 1'b0; fill_limit = 256; wr_cnt = 0;
        swap_at(522);
        check("swap522_line_req", 32'(line_req), 32'h1);
        check("swap522_line_num", 32'(line_num), 32'd0);
        check("swap522_ppu_ready", 32'(ppu_ready), 32'h1);
        check("swap522_underrun", 32'(underrun), 32'h0);
        tick();
        check("line_req_one_clk", 32'(line_req), 32'h0);
        run_cycles(300);
        check("fill0_count", 32'(wr_cnt), 32'd256);
        check("fill0_ready_low", 32'(ppu_ready), 32'h0);

        wr_cnt = 0; ramp_mode = 1'b1;
        drive();
        swap_at(524);
        check("swap524_line_req", 32'(line_req), 32'h1);
        check("swap524_line_num", 32'(line_num), 32'd1);
        check("swap524_underrun", 32'(underrun), 32'h0);

        chk_row = 0; tab_sel = 1;
        run_cycles(800);
        chk_row = 1; tab_sel = 2;
        wr_cnt = 0; fill_limit = 100;
        drive();
        run_cycles(799);
        tick();
        check("swap1_line_req", 32'(line_req), 32'h1);
        check("swap1_line_num", 32'(line_num), 32'd2);
        check("swap1_underrun", 32'(underrun), 32'h0);

        // Ramp line on row 2, with an en-low hold while the h input keeps moving.
        chk_row = 2; tab_sel = 3;
        run_cycles(100);
        en_v = 1'b0; h_pos = 300;
        drive();
        repeat (5) tick();
        check("en_hold_rgb", 32'(rgb_now()), 32'h07F);
        check("en_hold_h_sync", 32'(h_sync), 32'h1);
        en_v = 1'b1; h_pos = 100;
        drive();
        run_cycles(700);
        chk_row = -1; tab_sel = 0;
        run_cycles(799);
        tick();
        check("swap3_line_num", 32'(line_num), 32'd3);
        check("swap3_underrun_set", 32'(underrun), 32'h1);
        run_cycles(10);
        check("underrun_sticky", 32'(underrun), 32'h1);

        wr_cnt = 0; fill_limit = 256;
        swap_at(475);
        check("swap475_line_req", 32'(line_req), 32'h1);
        check("swap475_line_num", 32'(line_num), 32'd239);
        run_cycles(300);
        check("fill239_count", 32'(wr_cnt), 32'd256);
        swap_at(477);
        check("swap477_no_line_req", 32'(line_req), 32'h0);
        check("swap477_ready_low", 32'(ppu_ready), 32'h0);

        wr_cnt = 0;
        blank_mon = 1'b1;
        jump(489, 790);
        run_cycles(2500);
        blank_mon = 1'b0;
        check("vblank_rgb_zero_cycles_bad", 32'(blank_rgb_bad), 32'd0);
        check("vblank_ready_cycles_bad", 32'(blank_ready_bad), 32'd0);
        check("vblank_writes", 32'(wr_cnt), 32'd0);
        check("underrun_still_set", 32'(underrun), 32'h1);

        // Pixel offered in the swap cycle must be refused.
        wr_cnt = 0; fill_limit = 10;
        swap_at(522);
        check("swap522b_line_num", 32'(line_num), 32'd0);
        run_cycles(50);
        check("partial_fill_count", 32'(wr_cnt), 32'd10);
        fill_limit = 256;
        jump(524, 795);
        repeat (3) tick();
        check("ready_before_swap", 32'(ppu_ready), 32'h1);
        tick();
        check("swap_drops_write", 32'(ppu_ready), 32'h0);
        tick();
        check("swap524b_line_num", 32'(line_num), 32'd1);
        check("ready_after_swap", 32'(ppu_ready), 32'h1);

        // Reset mid-fill abandons the line without flagging underrun.
        wr_cnt = 0; fill_limit = 50;
        drive();
        run_cycles(60);
        rst = 1'b1;
        drive();
        repeat (2) tick();
        reset_checks("midrst");
        rst = 1'b0;
        drive();
        swap_at(1);
        check("post_rst_line_num", 32'(line_num), 32'd2);
        check("post_rst_underrun", 32'(underrun), 32'h0);
        check("post_rst_ready", 32'(ppu_ready), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
